// File: rtl/ball_engine_pkg.sv
// Shared definitions for the ball engine and the renderer: FSM encoding, geometry defaults, serve points.
package ball_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_MISS = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam int WIDTH_DEF        = 8;
    localparam int BIT_OF_WIDTH_DEF = 3;
    localparam int SIZE_DEF         = 2;

    // Serve after reset, game restart, or a top-player miss.
    localparam int SERVE_RST_X = 3;
    localparam int SERVE_RST_Y = 3;
    // Serve after a bottom-player miss.
    localparam int SERVE_BOT_X = 4;
    localparam int SERVE_BOT_Y = 4;

    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/ball_engine_paddle_hit.sv
// Combinational paddle coverage test: is column col under the paddle at position player?
// MIRROR selects the top paddle, whose position counts from the right edge.
module paddle_hit
    import ball_engine_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int BIT_OF_WIDTH = BIT_OF_WIDTH_DEF,
    parameter int SIZE         = SIZE_DEF,
    parameter bit MIRROR       = 1'b0
) (
    input  logic [BIT_OF_WIDTH-1:0] col,
    input  logic [BIT_OF_WIDTH-1:0] player,
    output logic                    hit
);

    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < SIZE; k++) begin
            if (MIRROR) begin
                if (int'(col) == WIDTH - 1 - int'(player) - k) hit = 1'b1;
            end else begin
                if (int'(col) == int'(player) + k) hit = 1'b1;
            end
        end
        // Corner columns are never covered by a paddle.
        if (int'(col) < 1 || int'(col) > WIDTH - 2) hit = 1'b0;
    end

endmodule

// File: rtl/ball_engine.sv
// Pong ball engine: steps the ball one cell per tick, bounces on walls and paddles, scores misses.
// pos_ball reflects a tick on the following cycle; misses freeze the ball for HOLD_TICKS ticks.
module ball_engine
    import ball_engine_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int BIT_OF_WIDTH = BIT_OF_WIDTH_DEF,
    parameter int SIZE         = SIZE_DEF,
    parameter int HOLD_TICKS   = 4,
    parameter int WIN_SCORE    = 9
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic                      start,
    input  logic [BIT_OF_WIDTH-1:0]   player_top,
    input  logic [BIT_OF_WIDTH-1:0]   player_down,
    output logic [2*BIT_OF_WIDTH-1:0] pos_ball,
    output logic [3:0]                score_top,
    output logic [3:0]                score_down,
    output logic                      point,
    output logic                      game_over
);

    localparam int BW = BIT_OF_WIDTH;
    localparam int CW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [BW-1:0] C_ZERO    = '0;
    localparam logic [BW-1:0] C_ONE     = BW'(1);
    localparam logic [BW-1:0] C_TWO     = BW'(2);
    localparam logic [BW-1:0] C_MAX     = BW'(WIDTH - 1);
    localparam logic [BW-1:0] C_EDGE    = BW'(WIDTH - 2);
    localparam logic [BW-1:0] C_EDGE_IN = BW'(WIDTH - 3);
    localparam logic [BW-1:0] RST_X     = BW'(SERVE_RST_X);
    localparam logic [BW-1:0] RST_Y     = BW'(SERVE_RST_Y);
    localparam logic [BW-1:0] BOT_X     = BW'(SERVE_BOT_X);
    localparam logic [BW-1:0] BOT_Y     = BW'(SERVE_BOT_Y);
    localparam logic [CW-1:0] CNT_LAST  = CW'(HOLD_TICKS - 1);
    localparam logic [3:0]    WIN       = 4'(WIN_SCORE);

    state_t          state, state_n;
    logic [BW-1:0]   x, y, x_n, y_n, nx, ny;
    logic            dx_neg, dy_neg, dx_neg_n, dy_neg_n, step_dx_neg, step_dy_neg;
    logic [CW-1:0]   cnt, cnt_n;
    logic [3:0]      score_top_n, score_down_n;
    logic            hit_top, hit_down, miss_top, miss_down;

    // Horizontal step with wall reflection; feeds the paddle test below.
    always_comb begin
        step_dx_neg = dx_neg;
        if (dx_neg ? (x == C_ZERO) : (x == C_MAX)) begin
            step_dx_neg = ~dx_neg;
            nx          = dx_neg ? x + C_ONE : x - C_ONE;
        end else begin
            nx          = dx_neg ? x - C_ONE : x + C_ONE;
        end
    end

    paddle_hit #(.WIDTH(WIDTH), .BIT_OF_WIDTH(BW), .SIZE(SIZE), .MIRROR(1'b1)) u_hit_top (
        .col    (nx),
        .player (player_top),
        .hit    (hit_top)
    );

    paddle_hit #(.WIDTH(WIDTH), .BIT_OF_WIDTH(BW), .SIZE(SIZE), .MIRROR(1'b0)) u_hit_down (
        .col    (nx),
        .player (player_down),
        .hit    (hit_down)
    );

    always_comb begin
        ny          = y;
        step_dy_neg = dy_neg;
        miss_top    = 1'b0;
        miss_down   = 1'b0;
        if (y == C_ONE && dy_neg) begin
            if (hit_top) begin
                step_dy_neg = 1'b0;
                ny          = C_TWO;
            end else begin
                ny       = C_ZERO;
                miss_top = 1'b1;
            end
        end else if (y == C_EDGE && !dy_neg) begin
            if (hit_down) begin
                step_dy_neg = 1'b1;
                ny          = C_EDGE_IN;
            end else begin
                ny        = C_MAX;
                miss_down = 1'b1;
            end
        end else begin
            ny = dy_neg ? y - C_ONE : y + C_ONE;
        end
    end

    always_comb begin
        state_n      = state;
        x_n          = x;
        y_n          = y;
        dx_neg_n     = dx_neg;
        dy_neg_n     = dy_neg;
        cnt_n        = cnt;
        score_top_n  = score_top;
        score_down_n = score_down;
        case (state)
            ST_IDLE: begin
                if (start) state_n = ST_PLAY;
            end
            ST_PLAY: begin
                if (tick) begin
                    x_n      = nx;
                    y_n      = ny;
                    dx_neg_n = step_dx_neg;
                    dy_neg_n = step_dy_neg;
                    if (miss_top) begin
                        score_down_n = sat_inc(score_down, WIN);
                        state_n      = ST_MISS;
                        cnt_n        = '0;
                    end else if (miss_down) begin
                        score_top_n = sat_inc(score_top, WIN);
                        state_n     = ST_MISS;
                        cnt_n       = '0;
                    end
                end
            end
            ST_MISS: begin
                if (tick) begin
                    if (cnt == CNT_LAST) begin
                        cnt_n = '0;
                        if (score_top == WIN || score_down == WIN) begin
                            state_n = ST_OVER;
                        end else begin
                            state_n = ST_IDLE;
                            // The frozen row tells which side missed.
                            if (y == C_MAX) begin
                                x_n      = BOT_X;
                                y_n      = BOT_Y;
                                dx_neg_n = 1'b0;
                                dy_neg_n = 1'b1;
                            end else begin
                                x_n      = RST_X;
                                y_n      = RST_Y;
                                dx_neg_n = 1'b0;
                                dy_neg_n = 1'b0;
                            end
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            ST_OVER: begin
                if (start) begin
                    state_n      = ST_IDLE;
                    score_top_n  = '0;
                    score_down_n = '0;
                    x_n          = RST_X;
                    y_n          = RST_Y;
                    dx_neg_n     = 1'b0;
                    dy_neg_n     = 1'b0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            x          <= RST_X;
            y          <= RST_Y;
            dx_neg     <= 1'b0;
            dy_neg     <= 1'b0;
            cnt        <= '0;
            score_top  <= '0;
            score_down <= '0;
        end else begin
            state      <= state_n;
            x          <= x_n;
            y          <= y_n;
            dx_neg     <= dx_neg_n;
            dy_neg     <= dy_neg_n;
            cnt        <= cnt_n;
            score_top  <= score_top_n;
            score_down <= score_down_n;
        end
    end

    assign pos_ball  = {x, y};
    assign point     = (state == ST_MISS);
    assign game_over = (state == ST_OVER);

endmodule

// File: doc/ball_engine.md
BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 Parameter WIDTH, default 8, matrix columns and rows.
REQ-002 Parameter BIT_OF_WIDTH, default 3, coordinate width.
REQ-003 Parameter SIZE, default 2, paddle length in columns.
REQ-004 Parameter HOLD_TICKS, default 4, ticks the ball freezes after a miss.
REQ-005 Parameter WIN_SCORE, default 9, points that end the game.
REQ-006 clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 tick  in  1  one-cycle pulse that advances the ball by one step.
REQ-009 start  in  1  one-cycle pulse that serves the ball or restarts after game over.
REQ-010 player_top  in  3  top paddle position, same encoding the renderer uses.
REQ-011 player_down  in  3  bottom paddle position, same encoding the renderer uses.
REQ-012 pos_ball  out  6  ball position; bits [5:3] are x (column) and bits [2:0] are y (row).
REQ-013 score_top  out  4  points won by the top player.
REQ-014 score_down  out  4  points won by the bottom player.
REQ-015 point  out  1  high while in MISS.
REQ-016 game_over  out  1  high while in OVER.

Function
REQ-017 The block SHALL have four states: IDLE, PLAY, MISS and OVER.
REQ-018 The block SHALL hold direction registers dx and dy, each +1 or -1.
REQ-019 In IDLE, start SHALL move the block to PLAY; a tick in the same cycle SHALL be ignored.
REQ-020 In IDLE, pos_ball SHALL hold the serve position.
REQ-021 Step rule for x, on a tick in PLAY: nx = x+dx.
  - If nx leaves 0..WIDTH-1, dx SHALL flip and nx = x-dx.
  - Example: x=7, dx=+1 gives nx=6, dx=-1.
REQ-022 The top paddle SHALL cover columns (WIDTH-1-player_top-k) for k=0..SIZE-1, intersected with 1..WIDTH-2.
REQ-023 The bottom paddle SHALL cover columns (player_down+k) for k=0..SIZE-1, intersected with 1..WIDTH-2.
REQ-024 Step rule for y when y=1 and dy=-1:
  - nx on the top paddle: dy=+1 and ny=2;
  - otherwise: ny=0, score_down+1, next state MISS.
REQ-025 Step rule for y when y=WIDTH-2 and dy=+1:
  - nx on the bottom paddle: dy=-1 and ny=WIDTH-3;
  - otherwise: ny=WIDTH-1, score_top+1, next state MISS.
REQ-026 In every other PLAY case, ny = y+dy.
REQ-027 pos_ball SHALL show {nx, ny} in the cycle after the tick, i.e. one-cycle latency.
REQ-028 Wall reflection SHALL be applied before the paddle test in the same tick.
REQ-029 MISS SHALL freeze pos_ball and count HOLD_TICKS ticks.
REQ-030 When the MISS count completes: the block SHALL go to OVER if either score equals WIN_SCORE, otherwise to IDLE.
REQ-031 Serve position after the bottom player misses: (4,4), dx=+1, dy=-1.
REQ-032 Serve position after the top player misses, and after reset: (3,3), dx=+1, dy=+1.
REQ-033 In OVER, ticks SHALL be ignored and scores SHALL hold.
REQ-034 In OVER, start SHALL clear both scores, load the reset serve position and enter IDLE.
REQ-035 A score SHALL saturate at WIN_SCORE and never wrap.
REQ-036 start in PLAY or MISS SHALL be ignored.

Reset
REQ-037 reset SHALL put the block in IDLE.
REQ-038 reset SHALL set pos_ball=(3,3), dx=+1, dy=+1 and clear the MISS counter.
REQ-039 reset SHALL clear score_top, score_down, point and game_over.
REQ-040 reset SHALL take priority over tick and start in any state, including mid-play and mid-MISS.

Structure
REQ-041 A shared package SHALL hold the state encoding, the WIDTH, BIT_OF_WIDTH and SIZE defaults, and the serve coordinates.
REQ-042 The renderer SHALL use the same package.
REQ-043 The paddle coverage test SHALL be a combinational sub-module, paddle_hit, instantiated once per paddle.

Verification
REQ-044 Bottom miss: reset, start, player_down=0, 4 ticks.
  - pos_ball SHALL go (4,4), (5,5), (6,6), (7,7);
  - then score_top=1 and point=1.
REQ-045 Hold and re-serve: from REQ-044, 4 ticks.
  - point=0, state IDLE, pos_ball=(4,4).
REQ-046 Corner hit: from REQ-045, start, player_top=0, player_down=0, 8 ticks.
  - pos_ball SHALL go (5,3), (6,2), (7,1), (6,2), (5,3), (4,4), (3,5), (2,6);
  - a 9th tick SHALL give (1,5);
  - scores SHALL be unchanged.
REQ-047 Win: WIN_SCORE=2, two bottom misses.
  - game_over=1 after the second hold completes;
  - further ticks SHALL leave pos_ball unchanged;
  - start SHALL clear the scores and give IDLE at (3,3).
REQ-048 Reset mid-play: at pos_ball=(5,5), assert reset together with tick.
  - next cycle: pos_ball=(3,3), scores 0, state IDLE.
REQ-049 start and tick in the same cycle in IDLE.
  - state SHALL become PLAY with pos_ball unchanged;
  - the next tick SHALL give (4,4).
